round_scheduler: RTL

ROUND_SCHEDULER -- requirements
Module: round_scheduler

---
 rtl/round_scheduler.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/round_scheduler.sv
// -----------------------------------------------------------------------------
// round_scheduler
//
// Sequences a two-player trail game: map clear, pre-round countdown, alternating
// movement grants during play, a frozen hold after each collision, and scoring
// until one player reaches WIN_SCORE round wins.
//
// Ports
//   clk                input      system clock, rising-edge active
//   rst                input      asynchronous reset, active low
//   start              input      single-cycle game start request (IDLE/OVER)
//   player1_collision  input      collision flag of player 1
//   player2_collision  input      collision flag of player 2
//   selected_player    output [2] 00 hold, 01 player 1, 11 player 2
//   move_tick          output     one-cycle pulse every TICK_DIV cycles
//   map_clear          output     one-cycle trail erase request
//   countdown          output [3] remaining countdown ticks
//   score_1, score_2   output [4] round wins per player
//   winner             output [2] 00 none, 01 player 1, 11 player 2
//   game_state         output [3] IDLE=0 CLEAR=1 COUNT=2 PLAY=3 HOLD=4 OVER=5
// -----------------------------------------------------------------------------
module round_scheduler #(
    parameter int TICK_DIV        = 16_250_000,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int HOLD_TICKS      = 2,
    parameter int WIN_SCORE       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       player1_collision,
    input  logic       player2_collision,
    output logic [1:0] selected_player,
    output logic       move_tick,
    output logic       map_clear,
    output logic [2:0] countdown,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic [1:0] winner,
    output logic [2:0] game_state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [2:0]    CD_LOAD   = 3'(COUNTDOWN_TICKS);
    localparam logic [2:0]    HOLD_LOAD = 3'(HOLD_TICKS);
    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_COUNT = 3'd2,
        S_PLAY  = 3'd3,
        S_HOLD  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    countdown_q, countdown_d;
    logic [2:0]    hold_q, hold_d;
    logic          turn_q, turn_d;          // 0 = player 1, 1 = player 2
    logic [3:0]    score_1_q, score_1_d;
    logic [3:0]    score_2_q, score_2_d;
    logic [1:0]    winner_q, winner_d;
    logic [1:0]    selected_player_q, selected_player_d;
    logic          move_tick_q, move_tick_d;
    logic          map_clear_q, map_clear_d;

    logic tick_hit;
    logic any_col;
    logic hold_entry;

    function automatic logic is_running(input state_t s);
        return (s == S_COUNT) || (s == S_PLAY) || (s == S_HOLD);
    endfunction

    assign tick_hit = is_running(state_q) && (tick_cnt_q == TICK_LAST);
    assign any_col  = player1_collision | player2_collision;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_COUNT;
            S_COUNT: if (tick_hit && countdown_q <= 3'd1) state_d = S_PLAY;
            S_PLAY:  if (any_col) state_d = S_HOLD;
            S_HOLD: begin
                if (tick_hit && hold_q <= 3'd1) begin
                    state_d = (score_1_q == WIN || score_2_q == WIN) ? S_OVER : S_CLEAR;
                end
            end
            S_OVER:  if (start) state_d = S_CLEAR;
            default: state_d = S_IDLE;
        endcase
    end

    assign hold_entry = (state_q == S_PLAY) && (state_d == S_HOLD);

    // Datapath and registered-output next values
    always_comb begin
        // The tick phase restarts whenever the counter (re)starts running and on
        // entering HOLD, so every hold period lasts exactly HOLD_TICKS full ticks.
        if (!is_running(state_d) || !is_running(state_q) || hold_entry || tick_hit) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        countdown_d = countdown_q;
        if (state_d == S_CLEAR) begin
            countdown_d = CD_LOAD;
        end else if (state_q == S_COUNT && tick_hit && countdown_q != 3'd0) begin
            countdown_d = countdown_q - 3'd1;
        end

        hold_d = hold_q;
        if (hold_entry) begin
            hold_d = HOLD_LOAD;
        end else if (state_q == S_HOLD && tick_hit && hold_q != 3'd0) begin
            hold_d = hold_q - 3'd1;
        end

        // A collision in a tick cycle leaves PLAY, so the toggle is dropped.
        turn_d = turn_q;
        if (state_d == S_CLEAR) begin
            turn_d = 1'b0;
        end else if (state_q == S_PLAY && state_d == S_PLAY && tick_hit) begin
            turn_d = ~turn_q;
        end

        score_1_d = score_1_q;
        score_2_d = score_2_q;
        if ((state_q == S_IDLE || state_q == S_OVER) && start) begin
            score_1_d = '0;
            score_2_d = '0;
        end else if (state_q == S_PLAY) begin
            // Crashing player concedes the round; a simultaneous crash is a draw.
            if (player1_collision && !player2_collision && score_2_q < WIN) begin
                score_2_d = score_2_q + 4'd1;
            end
            if (player2_collision && !player1_collision && score_1_q < WIN) begin
                score_1_d = score_1_q + 4'd1;
            end
        end

        winner_d = 2'b00;
        if (state_d == S_OVER) begin
            winner_d = (score_1_q == WIN) ? 2'b01 : 2'b11;
        end

        selected_player_d = 2'b00;
        if (state_d == S_PLAY) begin
            selected_player_d = turn_d ? 2'b11 : 2'b01;
        end

        // Registered from next-state values so the pulse coincides with the
        // counter sitting at TICK_DIV-1.
        move_tick_d = is_running(state_d) && (tick_cnt_d == TICK_LAST);
        map_clear_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q        <= '0;
            countdown_q       <= '0;
            hold_q            <= '0;
            turn_q            <= 1'b0;
            score_1_q         <= '0;
            score_2_q         <= '0;
            winner_q          <= 2'b00;
            selected_player_q <= 2'b00;
            move_tick_q       <= 1'b0;
            map_clear_q       <= 1'b0;
        end else begin
            tick_cnt_q        <= tick_cnt_d;
            countdown_q       <= countdown_d;
            hold_q            <= hold_d;
            turn_q            <= turn_d;
            score_1_q         <= score_1_d;
            score_2_q         <= score_2_d;
            winner_q          <= winner_d;
            selected_player_q <= selected_player_d;
            move_tick_q       <= move_tick_d;
            map_clear_q       <= map_clear_d;
        end
    end

    assign selected_player = selected_player_q;
    assign move_tick       = move_tick_q;
    assign map_clear       = map_clear_q;
    assign countdown       = countdown_q;
    assign score_1         = score_1_q;
    assign score_2         = score_2_q;
    assign winner          = winner_q;
    assign game_state      = state_q;

endmodule
